bus_master_arbiter: RTL

//  Shares the single serial bus between two masters (M1, M2) ahead of the slave-select arbiter.

---
 rtl/bus_master_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bus_master_arbiter.sv
// rtl/bus_master_arbiter.sv - two-master serial bus arbiter with round-robin tie break and hold-time preemption
//
// Purpose:
//   Shares one serial bus between masters M1 and M2 ahead of the slave-select arbiter.
//   A master holds its request high for the whole transaction and receives a registered
//   one-hot grant. Simultaneous requests alternate via round-robin. Once the holder has
//   been granted for MAX_HOLD cycles and the other master is waiting, the holder is
//   preempted. Every release passes through a single RELEASE turnaround cycle.
//   The granted master's serial lines are muxed onto the bus, and bus ready is returned
//   only to the granted master.
//
// Ports:
//   clk                  in   clock; all state updates on the rising edge
//   reset                in   synchronous, active-high
//   i_m1_req/i_m2_req    in   bus request from M1/M2
//   o_m1_grant/o_m2_grant out registered grant; one-hot or zero
//   i_mX_address         in   serial address bit from master X
//   i_mX_data            in   serial data bit from master X
//   i_mX_valid           in   data valid from master X
//   i_mX_address_valid   in   address valid strobe from master X
//   o_mX_ready           out  i_bus_ready gated by mX grant
//   o_bus_address        out  muxed address
//   o_bus_data           out  muxed data
//   o_bus_valid          out  muxed valid
//   o_bus_address_valid  out  muxed address valid
//   i_bus_ready          in   ready from the slave-select arbiter
//   o_bus_busy           out  high in GRANT1, GRANT2 and RELEASE
module bus_master_arbiter #(
  parameter int MAX_HOLD = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_m1_req,
  input  logic i_m2_req,
  output logic o_m1_grant,
  output logic o_m2_grant,
  input  logic i_m1_address,
  input  logic i_m1_data,
  input  logic i_m1_valid,
  input  logic i_m1_address_valid,
  output logic o_m1_ready,
  input  logic i_m2_address,
  input  logic i_m2_data,
  input  logic i_m2_valid,
  input  logic i_m2_address_valid,
  output logic o_m2_ready,
  output logic o_bus_address,
  output logic o_bus_data,
  output logic o_bus_valid,
  output logic o_bus_address_valid,
  input  logic i_bus_ready,
  output logic o_bus_busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT1  = 2'd1,
    S_GRANT2  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // r_last: 0 = M1 was last granted, 1 = M2 was last granted.
  localparam logic LAST_M1 = 1'b0;
  localparam logic LAST_M2 = 1'b1;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_m1_grant;
  logic          r_m2_grant;
  logic [CW-1:0] r_hold_cnt;
  logic          r_last;
  logic          w_enter_g1;
  logic          w_enter_g2;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        // On a tie, the master that did not hold the bus last wins.
        if (i_m1_req && (!i_m2_req || r_last == LAST_M2)) begin
          w_next_state = S_GRANT1;
        end else if (i_m2_req) begin
          w_next_state = S_GRANT2;
        end
      end
      S_GRANT1: begin
        if (!i_m1_req || (r_hold_cnt == HOLD_LIMIT && i_m2_req)) begin
          w_next_state = S_RELEASE;
        end
      end
      S_GRANT2: begin
        if (!i_m2_req || (r_hold_cnt == HOLD_LIMIT && i_m1_req)) begin
          w_next_state = S_RELEASE;
        end
      end
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // GRANTx is only ever reached from IDLE, so the check against the current state
  // is purely defensive.
  assign w_enter_g1 = (w_next_state == S_GRANT1) && (r_state != S_GRANT1);
  assign w_enter_g2 = (w_next_state == S_GRANT2) && (r_state != S_GRANT2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_m1_grant <= 1'b0;
      r_m2_grant <= 1'b0;
      r_hold_cnt <= '0;
      r_last     <= LAST_M2;
    end else begin
      r_state    <= w_next_state;
      // Grants are taken from next-state so they rise on the same edge the FSM enters GRANTx.
      r_m1_grant <= (w_next_state == S_GRANT1);
      r_m2_grant <= (w_next_state == S_GRANT2);
      if (w_enter_g1 || w_enter_g2) begin
        r_hold_cnt <= '0;
        r_last     <= w_enter_g2 ? LAST_M2 : LAST_M1;
      end else if ((r_state == S_GRANT1 || r_state == S_GRANT2) && r_hold_cnt != HOLD_LIMIT) begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
    end
  end

  assign o_m1_grant = r_m1_grant;
  assign o_m2_grant = r_m2_grant;
  assign o_bus_busy = (r_state != S_IDLE);

  // The datapath is an AND-OR mux driven by the one-hot grant flops; it reads zero when no master is granted.
  assign o_bus_address       = (r_m1_grant & i_m1_address)       | (r_m2_grant & i_m2_address);
  assign o_bus_data          = (r_m1_grant & i_m1_data)          | (r_m2_grant & i_m2_data);
  assign o_bus_valid         = (r_m1_grant & i_m1_valid)         | (r_m2_grant & i_m2_valid);
  assign o_bus_address_valid = (r_m1_grant & i_m1_address_valid) | (r_m2_grant & i_m2_address_valid);
  assign o_m1_ready          = r_m1_grant & i_bus_ready;
  assign o_m2_ready          = r_m2_grant & i_bus_ready;

endmodule
